// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, alu_op encodings, R-type funct values
// and the immediate-extension rule used at the execute-entry register.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_RTYPE = 2'b10,
    ALU_OP_ORI   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // OR-immediate is a logical op, so its immediate is zero-extended.
  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic [1:0] op);
    logic [31:0] ext;
    if (op == ALU_OP_ORI) begin
      ext = {16'h0000, imm};
    end else begin
      ext = {{16{imm[15]}}, imm};
    end
    return ext;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct into the 4-bit ALU control code,
// flagging R-type function fields the ALU does not implement.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal
);

  // Main decode; unsupported funct yields AND code plus the illegal flag.
  always_comb begin
    alu_control = ALU_AND;
    illegal     = 1'b0;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_ORI: alu_control = ALU_OR;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_NOR: alu_control = ALU_NOR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default: begin
            alu_control = ALU_AND;
            illegal     = 1'b1;
          end
        endcase
      end
      default: begin
        alu_control = ALU_AND;
        illegal     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards operands at capture, refreshes held
// operands from MEM/WB while stalled, and presents registered ALU inputs.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        rd_addr,
  input  logic [15:0]       imm16,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              alu_src,
  input  logic              flush,
  input  logic              exmem_wen,
  input  logic [4:0]        exmem_waddr,
  input  logic [DATA_W-1:0] exmem_wdata,
  input  logic              memwb_wen,
  input  logic [4:0]        memwb_waddr,
  input  logic [DATA_W-1:0] memwb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [4:0]        out_rd,
  output logic              out_illegal
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_val_q, rs_val_d, rt_val_q, rt_val_d, imm_q, imm_d;
  logic [4:0]        rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_q, rd_d;
  logic              src_q, src_d, illegal_q, illegal_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [3:0]        dec_ctrl;
  logic              dec_illegal, capture;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;

  alu_ctrl_decode u_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (dec_ctrl),
    .illegal     (dec_illegal)
  );

  // Handshake, capture-time forwarding (EX/MEM beats MEM/WB) and next state.
  always_comb begin
    in_ready = !flush && (!valid_q || out_ready);
    capture  = in_valid && in_ready;

    if (exmem_wen && (exmem_waddr == rs_addr) && (rs_addr != 5'd0)) begin
      rs_fwd = exmem_wdata;
    end else if (memwb_wen && (memwb_waddr == rs_addr) && (rs_addr != 5'd0)) begin
      rs_fwd = memwb_wdata;
    end else begin
      rs_fwd = rs_data;
    end
    if (exmem_wen && (exmem_waddr == rt_addr) && (rt_addr != 5'd0)) begin
      rt_fwd = exmem_wdata;
    end else if (memwb_wen && (memwb_waddr == rt_addr) && (rt_addr != 5'd0)) begin
      rt_fwd = memwb_wdata;
    end else begin
      rt_fwd = rt_data;
    end

    valid_d   = valid_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    imm_d     = imm_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_d      = rd_q;
    src_d     = src_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      rs_val_d  = rs_fwd;
      rt_val_d  = rt_fwd;
      imm_d     = extend_imm(imm16, alu_op);
      rs_addr_d = rs_addr;
      rt_addr_d = rt_addr;
      rd_d      = rd_addr;
      src_d     = alu_src;
      illegal_d = dec_illegal;
      ctrl_d    = dec_ctrl;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: keep the held operands current with MEM/WB writebacks.
      if (memwb_wen && (memwb_waddr == rs_addr_q) && (rs_addr_q != 5'd0)) begin
        rs_val_d = memwb_wdata;
      end else begin
        rs_val_d = rs_val_q;
      end
      if (memwb_wen && (memwb_waddr == rt_addr_q) && (rt_addr_q != 5'd0)) begin
        rt_val_d = memwb_wdata;
      end else begin
        rt_val_d = rt_val_q;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      imm_q     <= '0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      rd_q      <= 5'd0;
      src_q     <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= 4'd0;
    end else begin
      valid_q   <= valid_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      imm_q     <= imm_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_q      <= rd_d;
      src_q     <= src_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_a       = rs_val_q;
  assign alu_b       = src_q ? imm_q : rt_val_q;
  assign alu_control = ctrl_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Execute-entry pipeline register that feeds the 32-bit ALU. It captures a decoded instruction's operands and resolves data hazards by forwarding from EX/MEM and MEM/WB. It decodes `alu_op`/`funct` into the 4-bit ALU control code and presents registered `alu_a`, `alu_b` and `alu_control` to the ALU combinationally. Upstream is the decode/register-read stage; downstream, the ALU plus the EX/MEM register consume the outputs under a valid/ready handshake.

## Interface
- `DATA_W`, default 32: datapath width. Only 32 is supported.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: stage can accept an entry this cycle.
- `rs_data`, `rt_data` in 32: register-file read values.
- `rs_addr`, `rt_addr`, `rd_addr` in 5: source and destination register numbers.
- `imm16` in 16: instruction immediate.
- `alu_op` in 2: 00 add, 01 sub, 10 R-type (use `funct`), 11 or-immediate.
- `funct` in 6: R-type function field.
- `alu_src` in 1: 1 selects the extended immediate as operand B.
- `flush` in 1: kill the held entry and the incoming entry.
- `exmem_wen` in 1, `exmem_waddr` in 5, `exmem_wdata` in 32: EX/MEM forwarding source.
- `memwb_wen` in 1, `memwb_waddr` in 5, `memwb_wdata` in 32: MEM/WB forwarding source.
- `out_valid` out 1: held entry valid.
- `out_ready` in 1: downstream accepts the held entry.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_control` out 4: ALU operation code.
- `out_rd` out 5: destination register of the held entry.
- `out_illegal` out 1: held entry carried an unsupported `funct`.

## Operation
- **Decode.**
  - `alu_op` 00 → 0010 (ADD).
  - `alu_op` 01 → 0110 (SUB).
  - `alu_op` 11 → 0001 (OR).
  - `alu_op` 10, by `funct`: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 100111→1100, 101010→0111.
  - Any other `funct` → `alu_control` 0000 and `out_illegal`=1.
- **Immediate.** Sign-extended for `alu_op` 00/01/10; zero-extended for 11.
- **Forwarding at capture**, per source operand:
  - If `exmem_wen` and `exmem_waddr` equals the source address and is non-zero → use `exmem_wdata`.
  - Else the same test on MEM/WB → use `memwb_wdata`.
  - Else use the register-file value.
  - Address 0 is never forwarded.
- **Stored state.**
  - Forwarded rs/rt values are stored raw, together with `rs_addr`/`rt_addr`, the extended immediate and `alu_src`.
  - `alu_b` = `alu_src` ? stored immediate : stored rt value, computed combinationally from the registers.
- **Hold refresh.** While `out_valid && !out_ready`, a MEM/WB write whose address matches a held non-zero rs/rt address overwrites that stored raw value in the same edge.
- **Handshake.**
  - `in_ready` = `!flush && (!out_valid || out_ready)`.
  - Capture happens on `in_valid && in_ready`.
  - If `out_valid && out_ready` with no capture, `out_valid` goes to 0.
- **Flush.** Has priority over capture and hold; the next edge sets `out_valid` to 0. Data registers may keep stale values.
- **Reset.** Highest priority, synchronous. Clears `out_valid` and `out_illegal`, and zeroes `alu_a`, `alu_b`, `alu_control` and `out_rd`. A reset mid-hold discards the held entry.

## Timing
- Latency: 1 cycle from the accepting edge to `out_valid`. Throughput: 1 entry per cycle while `out_ready`=1.
- Capture and drain on the same edge is allowed (back-to-back).
- Outputs change only on `clk` edges; no combinational path from `in_*` to `alu_*`.
- `in_ready` depends combinationally on `out_ready` and `flush` only.
- `flush` and `rst` asserted in the same cycle: reset values result.

## Structure
- Shared package `alu_pkg` holds:
  - ALU control constants: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`.
  - `alu_op` encodings.
  - R-type `funct` constants.
- The ALU itself imports the same package.
- Sub-module `alu_ctrl_decode` (combinational): `alu_op`, `funct` → `alu_control`, `illegal`.

## Test plan
- **R-type add and SLT.**
  - `alu_op`=10, `funct`=100000, `rs_data`=5, `rt_data`=7 → next cycle `out_valid`=1, `alu_control`=0010, `alu_a`=5, `alu_b`=7.
  - `funct`=101010 → `alu_control`=0111.
- **Immediates.**
  - `alu_op`=00, `alu_src`=1, `imm16`=FFFC → `alu_b`=FFFF_FFFC.
  - `alu_op`=11, `imm16`=8000 → `alu_b`=0000_8000, `alu_control`=0001.
- **Forward priority.**
  - `rs_addr`=3, EX/MEM writes r3=AA and MEM/WB writes r3=BB → `alu_a`=AA.
  - `rs_addr`=0 with both writes targeting r0 → `alu_a`=`rs_data`.
- **Stall.**
  - Hold `out_ready`=0 for 3 cycles → `in_ready`=0 and outputs stable.
  - A MEM/WB write of r7=55 to the held `rt_addr`=7 → `alu_b`=55 one edge later.
  - `out_ready`=1 → drain and accept the next entry on the same edge.
- **Flush and reset.**
  - `flush` with `in_valid`=1 → `out_valid`=0 next cycle and the entry is dropped.
  - `rst` during a hold → all outputs read 0 next edge.
- **Illegal function.** `alu_op`=10, `funct`=001000 → `out_illegal`=1, `alu_control`=0000.
